pipe_skid_buf: RTL and testbench

//  Two-entry valid/ready skid buffer feeding the 62-bit pipeline register stage.

---
 rtl/pipe_skid_buf.sv | 101 ++++++++++
 tb/tb_pipe_skid_buf.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer in front of the 62-bit pipeline register.
// in_ready and out_valid are decoded from state only, so the upstream ready
// path never sees the downstream out_ready combinationally.
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 62
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             pop;

  // Handshake qualifiers and register-only output decode.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and datapath selection; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (accept && !pop) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (accept && pop) begin
            main_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf: directed scenarios plus a randomized
// run compared against a queue-based model of the buffer contents.
module tb_pipe_skid_buf;

  localparam int unsigned W = 62;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  // Model: the ordered list of entries the buffer should hold, and whether
  // the head register is known to be cleared (after reset or flush).
  logic [W-1:0] q[$];
  bit           head_zero = 1'b1;

  pipe_skid_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the currently driven inputs; model advances alongside.
  task automatic tick();
    bit           acc;
    bit           pp;
    logic [W-1:0] dummy;
    acc = in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      q.delete();
      head_zero = 1'b1;
    end else begin
      if (pp) dummy = q.pop_front();
      if (acc) begin
        q.push_back(in_data);
        head_zero = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  endtask

  task automatic fill_ab();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = W'(64'hA); tick();
    in_data = W'(64'hB); tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    // Initial reset state.
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_init: out_valid=%b in_ready=%b occ=%0d out_data=%h, want 0 1 0 0",
               out_valid, in_ready, occupancy, out_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_ab();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL reset_prefill_occ: occ=%0d want 2", occupancy);
    end
    // Assert reset mid-cycle, away from any edge.
    #2 rst_n = 1'b0;
    #1;
    q.delete(); head_zero = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b in_ready=%b occ=%0d out_data=%h, want 0 1 0 0",
               out_valid, in_ready, occupancy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = W'(k);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(k) || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d: out_valid=%b out_data=%h occ=%0d, want 1 %h 1",
                 k, out_valid, out_data, occupancy, W'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: out_valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall();
    fill_ab();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== W'(64'hA)) begin
      errors++;
      $display("FAIL stall_full: occ=%0d in_ready=%b out_data=%h, want 2 0 a",
               occupancy, in_ready, out_data);
    end
    tick();
    checks++;
    if (occupancy !== 2'd2 || out_data !== W'(64'hA) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: occ=%0d out_data=%h out_valid=%b, want 2 a 1",
               occupancy, out_data, out_valid);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (occupancy !== 2'd1 || out_data !== W'(64'hB)) begin
      errors++;
      $display("FAIL stall_pop1: occ=%0d out_data=%h, want 1 b", occupancy, out_data);
    end
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_pop2: occ=%0d out_valid=%b in_ready=%b, want 0 0 1",
               occupancy, out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    fill_ab();
    in_valid = 1'b1; in_data = W'(64'hC); out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_ready: in_ready=%b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_data !== W'(64'hB) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_step1: out_data=%h occ=%0d in_ready=%b, want b 1 1",
               out_data, occupancy, in_ready);
    end
    tick();
    checks++;
    if (out_data !== W'(64'hC) || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL fullpop_step2: out_data=%h occ=%0d, want c 1", out_data, occupancy);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_drain: occ=%0d out_valid=%b, want 0 0", occupancy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    fill_ab();
    flush = 1'b1; in_valid = 1'b1; in_data = W'(64'hD);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: occ=%0d out_valid=%b out_data=%h in_ready=%b, want 0 0 0 1",
               occupancy, out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data === W'(64'hD)) begin
        errors++;
        $display("FAIL flush_ghost_%0d: out_valid=%b out_data=%h, want 0 and not d",
                 i, out_valid, out_data);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] r;
    bit          rdy_before;
    for (int c = 0; c < 10000; c++) begin
      r         = {$urandom, $urandom};
      in_data   = r[W-1:0];
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 2);
      #1;
      checks++;
      if (occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2) ||
          out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d: occ=%0d in_ready=%b out_valid=%b, want occ=%0d",
                 c, occupancy, in_ready, out_valid, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if (out_data !== q[0]) begin
          errors++;
          $display("FAIL rand_head c=%0d: out_data=%h want %h", c, out_data, q[0]);
        end
      end else if (head_zero) begin
        checks++;
        if (out_data !== '0) begin
          errors++;
          $display("FAIL rand_zero c=%0d: out_data=%h want 0", c, out_data);
        end
      end
      // in_ready must not move when out_ready changes within the cycle.
      rdy_before = in_ready;
      out_ready  = ~out_ready;
      #1;
      checks++;
      if (in_ready !== rdy_before) begin
        errors++;
        $display("FAIL rand_ready_path c=%0d: in_ready=%b want %b", c, in_ready, rdy_before);
      end
      out_ready = ~out_ready;
      #1;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    test_reset();
    test_streaming();
    test_stall();
    test_full_pop();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
